// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read channel, core redirect,
// and the instruction hand-off to the core.
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  redirect_valid, redirect_pc,
        output instr_valid, instr, instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output redirect_valid, redirect_pc,
        input  instr_valid, instr, instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory over req/ack and buffers
// returned words in a small FIFO in front of the core. Redirects flush and restart.
//
// state | meaning
// IDLE  | may issue a read at pc when a buffer slot is free
// WAIT  | read outstanding, address held until ack
// DROP  | read outstanding but redirected; its data is discarded on ack
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input logic            clk,
    input logic            reset,
    instr_fetch_if.master  bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t        state;
    logic [31:0]   pc;
    logic [31:0]   held_addr;
    logic [31:0]   addr;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   buf_instr [DEPTH];
    logic [31:0]   buf_pc    [DEPTH];
    logic          req;
    logic          ack;
    logic          push;
    logic          pop;
    logic          nonempty;

    always_comb begin
        req = 1'b0;
        case (state)
            IDLE:       req = (count < FULL) & ~bus.redirect_valid;
            WAIT, DROP: req = 1'b1;
            default:    req = 1'b0;
        endcase
        if (reset) req = 1'b0;
    end

    // In WAIT held_addr equals pc; in DROP pc already points at the redirect target.
    assign addr     = (state == IDLE) ? pc : held_addr;
    assign ack      = req & bus.imem_ack;
    assign push     = ack & ~bus.redirect_valid & (state != DROP);
    assign nonempty = (count != '0);
    assign pop      = bus.instr_valid & bus.instr_ready;

    assign bus.imem_req    = req;
    assign bus.imem_addr   = addr;
    assign bus.instr_valid = ~reset & nonempty & ~bus.redirect_valid;
    assign bus.instr       = nonempty ? buf_instr[rd_ptr] : 32'h0;
    assign bus.instr_pc    = nonempty ? buf_pc[rd_ptr]    : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            held_addr <= RESET_PC;
        end else if (bus.redirect_valid) begin
            pc <= {bus.redirect_pc[31:2], 2'b00};
            case (state)
                WAIT, DROP: state <= ack ? IDLE : DROP;
                default:    state <= IDLE;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        held_addr <= pc;
                        if (ack) pc <= pc + 32'd4;
                        else     state <= WAIT;
                    end
                end
                WAIT: begin
                    if (ack) begin
                        pc    <= pc + 32'd4;
                        state <= IDLE;
                    end
                end
                DROP: begin
                    if (ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.redirect_valid) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Buffer storage carries no reset; count gates what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wr_ptr] <= bus.imem_rdata;
            buf_pc[wr_ptr]    <= addr;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed corner sequences, a redirect
// vector table, and a randomized run checked against an instruction-stream model.
module tb_instr_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] KEY    = 32'hA5A5_0000;

    logic clk;
    logic reset;
    instr_fetch_if ifc();

    instr_fetch_unit #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // stimulus controls
    logic        tb_reset = 1'b1;
    logic        redir_v  = 1'b0;
    logic [31:0] redir_pc = 32'h0;
    logic        ready    = 1'b0;
    int          mem_lat  = 0;
    bit          mem_rand = 0;

    // memory slave state
    bit          busy = 0;
    int          cnt  = 0;
    int          lat  = 0;
    logic [31:0] saddr = 32'h0;

    // observations from the latest cycle
    logic        obs_req, obs_ack, obs_valid, obs_pop;
    logic [31:0] obs_addr, obs_instr, obs_pc;

    // instruction-stream model
    logic [31:0] exp_next = RST_PC;
    int          deliveries = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle time %0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        logic ack;
        @(negedge clk);
        reset              = tb_reset;
        ifc.redirect_valid = redir_v;
        ifc.redirect_pc    = redir_pc;
        ifc.instr_ready    = ready;
        #1;
        ack = 1'b0;
        if (!reset && ifc.imem_req) begin
            if (!busy) begin
                busy  = 1;
                cnt   = 0;
                lat   = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
                saddr = ifc.imem_addr;
            end else begin
                chk("addr_stable", ifc.imem_addr, saddr);
            end
            if (cnt == lat) ack = 1'b1;
            else cnt++;
        end else if (!reset && busy) begin
            chk("req_held", {31'b0, ifc.imem_req}, 32'd1);
        end
        ifc.imem_ack   = ack;
        ifc.imem_rdata = ifc.imem_addr ^ KEY;
        #1;
        obs_req   = ifc.imem_req;
        obs_addr  = ifc.imem_addr;
        obs_ack   = ack;
        obs_valid = ifc.instr_valid;
        obs_instr = ifc.instr;
        obs_pc    = ifc.instr_pc;
        obs_pop   = obs_valid & ready;
        if (ack || reset) busy = 0;
        if (reset) begin
            chk("valid_in_reset", {31'b0, obs_valid}, 32'd0);
            chk("req_in_reset", {31'b0, obs_req}, 32'd0);
            exp_next = RST_PC;
        end else if (redir_v) begin
            chk("valid_on_redirect", {31'b0, obs_valid}, 32'd0);
            exp_next = {redir_pc[31:2], 2'b00};
        end else if (obs_pop) begin
            chk("stream_pc", obs_pc, exp_next);
            chk("stream_instr", obs_instr, obs_pc ^ KEY);
            exp_next = obs_pc + 32'd4;
            deliveries++;
        end
    endtask

    task automatic do_reset();
        tb_reset = 1'b1;
        redir_v  = 1'b0;
        step();
        step();
        tb_reset = 1'b0;
    endtask

    task automatic wait_deliver(output logic [31:0] pc);
        bit got = 0;
        pc = 32'h0;
        for (int i = 0; i < 60 && !got; i++) begin
            step();
            got = obs_pop;
            pc  = obs_pc;
        end
        chk("deliver_timeout", {31'b0, got}, 32'd1);
    endtask

    task automatic wait_req(output logic [31:0] a);
        bit got = 0;
        a = 32'h0;
        for (int i = 0; i < 60 && !got; i++) begin
            step();
            got = obs_req;
            a   = obs_addr;
        end
        chk("req_timeout", {31'b0, got}, 32'd1);
    endtask

    typedef struct {
        logic [31:0] target;
        logic [31:0] p0;
        logic [31:0] p1;
        logic [31:0] p2;
    } redir_vec_t;

    redir_vec_t vecs [4];

    initial begin
        logic [31:0] pc;
        logic [31:0] a;
        int          rand_start;

        vecs[0] = '{32'h0000_1002, 32'h0000_1000, 32'h0000_1004, 32'h0000_1008};
        vecs[1] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[2] = '{32'h0000_0013, 32'h0000_0010, 32'h0000_0014, 32'h0000_0018};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

        reset              = 1'b1;
        ifc.imem_ack       = 1'b0;
        ifc.imem_rdata     = 32'h0;
        ifc.redirect_valid = 1'b0;
        ifc.redirect_pc    = 32'h0;
        ifc.instr_ready    = 1'b0;

        // Zero-wait memory, core always ready.
        mem_lat = 0;
        ready   = 1'b1;
        do_reset();
        step();
        chk("t1_valid_c0", {31'b0, obs_valid}, 32'd0);
        chk("t1_instr_c0", obs_instr, 32'h0);
        chk("t1_pc_c0", obs_pc, 32'h0);
        chk("t1_req_c0", {31'b0, obs_req}, 32'd1);
        chk("t1_addr_c0", obs_addr, RST_PC);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t1_valid", {31'b0, obs_valid}, 32'd1);
            chk("t1_pc", obs_pc, 32'(4 * k));
            chk("t1_instr", obs_instr, 32'(4 * k) ^ KEY);
        end

        // Three-wait memory with a stalled core fills exactly two entries.
        mem_lat = 3;
        ready   = 1'b0;
        do_reset();
        for (int k = 0; k < 20; k++) step();
        chk("t2_req_full", {31'b0, obs_req}, 32'd0);
        chk("t2_head_pc", obs_pc, 32'h0);
        ready = 1'b1;
        step();
        chk("t2_pop0", obs_pc, 32'h0);
        chk("t2_req_still_full", {31'b0, obs_req}, 32'd0);
        step();
        chk("t2_pop4", obs_pc, 32'h4);
        chk("t2_resume_req", {31'b0, obs_req}, 32'd1);
        chk("t2_resume_addr", obs_addr, 32'h8);
        step();
        chk("t2_only_two", {31'b0, obs_valid}, 32'd0);

        // Redirect while the read of pc 8 is outstanding.
        redir_v  = 1'b1;
        redir_pc = 32'h0000_1002;
        step();
        redir_v = 1'b0;
        step();
        chk("t3_drop_ack", {31'b0, obs_ack}, 32'd1);
        chk("t3_drop_addr", obs_addr, 32'h8);
        chk("t3_drop_valid", {31'b0, obs_valid}, 32'd0);
        wait_req(a);
        chk("t3_new_addr", a, 32'h0000_1000);
        wait_deliver(pc);
        chk("t3_first_pc", pc, 32'h0000_1000);

        // Redirect coincides with ack and ready while one entry is buffered.
        mem_lat = 1;
        ready   = 1'b0;
        do_reset();
        step();
        step();
        step();
        redir_v  = 1'b1;
        redir_pc = 32'h0000_2000;
        ready    = 1'b1;
        step();
        chk("t4_ack_same", {31'b0, obs_ack}, 32'd1);
        chk("t4_valid_same", {31'b0, obs_valid}, 32'd0);
        redir_v = 1'b0;
        step();
        chk("t4_empty_valid", {31'b0, obs_valid}, 32'd0);
        chk("t4_empty_instr", obs_instr, 32'h0);
        chk("t4_empty_pc", obs_pc, 32'h0);
        chk("t4_req", {31'b0, obs_req}, 32'd1);
        chk("t4_addr", obs_addr, 32'h0000_2000);
        wait_deliver(pc);
        chk("t4_first_pc", pc, 32'h0000_2000);

        // Redirect vector table, zero-wait memory.
        mem_lat = 0;
        ready   = 1'b1;
        for (int v = 0; v < 4; v++) begin
            redir_v  = 1'b1;
            redir_pc = vecs[v].target;
            step();
            redir_v = 1'b0;
            wait_deliver(pc);
            chk("vec_p0", pc, vecs[v].p0);
            wait_deliver(pc);
            chk("vec_p1", pc, vecs[v].p1);
            wait_deliver(pc);
            chk("vec_p2", pc, vecs[v].p2);
        end

        // Reset during an outstanding read with a buffered entry.
        mem_lat = 3;
        ready   = 1'b0;
        do_reset();
        for (int k = 0; k < 6; k++) step();
        tb_reset = 1'b1;
        step();
        step();
        chk("t6_req", {31'b0, obs_req}, 32'd0);
        chk("t6_valid", {31'b0, obs_valid}, 32'd0);
        chk("t6_instr", obs_instr, 32'h0);
        tb_reset = 1'b0;
        ready    = 1'b1;
        step();
        chk("t6_restart_req", {31'b0, obs_req}, 32'd1);
        chk("t6_restart_addr", obs_addr, RST_PC);
        wait_deliver(pc);
        chk("t6_first_pc", pc, RST_PC);

        // Randomized traffic against the stream model.
        mem_rand   = 1;
        rand_start = deliveries;
        for (int k = 0; k < 3000; k++) begin
            tb_reset = ($urandom_range(0, 299) == 0);
            redir_v  = ($urandom_range(0, 99) < 4);
            redir_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom;
            ready    = ($urandom_range(0, 9) < 7);
            step();
        end
        tb_reset = 1'b0;
        redir_v  = 1'b0;
        chk("rand_progress", {31'b0, (deliveries - rand_start) >= 300}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
